// File: rtl/demux_rr_scheduler.sv
// Round-robin scheduler in front of an 8-channel demultiplexer.
// Holds one upstream word at a time and offers it to the next enabled channel.
// A channel that stays not-ready too long is skipped, and the same word is
// retried on the next channel in order.
//
// Handshake: a word moves across an interface on a rising clock edge where
// valid and ready are both high. A valid, once raised, stays high with its
// data stable until that transfer happens. Ready may change freely.
// There are two exceptions to the "valid stays high" rule. If the targeted
// channel is disabled, or it times out, the scheduler withdraws ch_valid and
// searches again.
module demux_rr_scheduler #(
  parameter int DATA_W  = 8,
  parameter int NCH     = 8,
  parameter int SEL_W   = 3,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [NCH-1:0]    chan_en,
  output logic [SEL_W-1:0]  sel_out,
  output logic [DATA_W-1:0] data_out,
  output logic [NCH-1:0]    ch_valid,
  input  logic [NCH-1:0]    ch_ready,
  output logic [15:0]       sent_cnt,
  output logic              drop_pulse,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    SEND   = 2'd2
  } state_t;

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [DATA_W-1:0]  hold;
  logic [TIMER_W-1:0] timer;

  logic               found;
  logic [SEL_W-1:0]   found_ch;
  logic [SEL_W-1:0]   idx;
  int                 sum;

  assign state_dbg = state;

  // Channel after c, wrapping from the last channel back to 0.
  function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
    if (int'(c) == NCH - 1) return '0;
    else                    return c + 1'b1;
  endfunction

  // One-hot valid vector for channel c.
  function automatic logic [NCH-1:0] one_hot(input logic [SEL_W-1:0] c);
    logic [NCH-1:0] v;
    v    = '0;
    v[c] = 1'b1;
    return v;
  endfunction

  // Find the first enabled channel at or after ptr, wrapping past the last one.
  always_comb begin
    found    = 1'b0;
    found_ch = '0;
    idx      = '0;
    sum      = 0;
    for (int i = 0; i < NCH; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NCH) sum = sum - NCH;
      idx = SEL_W'(sum);
      if (!found && chan_en[idx]) begin
        found    = 1'b1;
        found_ch = idx;
      end
    end
  end

  // Scheduler FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      hold       <= '0;
      timer      <= '0;
      sel_out    <= '0;
      data_out   <= '0;
      ch_valid   <= '0;
      in_ready   <= 1'b0;
      sent_cnt   <= 16'd0;
      drop_pulse <= 1'b0;
      busy       <= 1'b0;
    end else begin
      drop_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            hold     <= in_data;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= SEARCH;
          end else begin
            in_ready <= |chan_en;
          end
        end
        SEARCH: begin
          // With an empty mask, wait here and keep the held word.
          if (found) begin
            sel_out  <= found_ch;
            data_out <= hold;
            ch_valid <= one_hot(found_ch);
            timer    <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          // Check order matters: a transfer beats a disable, and both beat a timeout.
          if (ch_ready[sel_out]) begin
            sent_cnt <= sent_cnt + 16'd1;
            ptr      <= next_ch(sel_out);
            ch_valid <= '0;
            // Re-arm in_ready so that IDLE can accept on its first cycle.
            in_ready <= |chan_en;
            busy     <= 1'b0;
            state    <= IDLE;
          end else if (!chan_en[sel_out]) begin
            ptr      <= next_ch(sel_out);
            ch_valid <= '0;
            state    <= SEARCH;
          end else if (timer == TIMER_W'(TIMEOUT)) begin
            drop_pulse <= 1'b1;
            ptr        <= next_ch(sel_out);
            ch_valid   <= '0;
            state      <= SEARCH;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: begin
          ch_valid <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Testbench for demux_rr_scheduler. It runs directed scenarios followed by
// randomized traffic. A transaction-level routing model predicts which channel
// each word lands on and how many timeout skips it causes.
module tb_demux_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  chan_en;
  logic [2:0]  sel_out;
  logic [7:0]  data_out;
  logic [7:0]  ch_valid;
  logic [7:0]  ch_ready;
  logic [15:0] sent_cnt;
  logic        drop_pulse;
  logic        busy;
  logic [1:0]  state_dbg;

  demux_rr_scheduler dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .chan_en(chan_en), .sel_out(sel_out), .data_out(data_out),
    .ch_valid(ch_valid), .ch_ready(ch_ready), .sent_cnt(sent_cnt),
    .drop_pulse(drop_pulse), .busy(busy), .state_dbg(state_dbg)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  // Scoreboard state
  int          n_tests   = 0;
  int          n_fail    = 0;
  logic [10:0] exp_q[$];
  logic [2:0]  model_ptr = 3'd0;
  int          exp_sent  = 0;
  int          exp_drops = 0;
  int          drop_seen = 0;
  logic        prev_valid = 1'b0;
  logic [2:0]  prev_sel;
  logic [7:0]  prev_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Routing model: a word goes to the first enabled channel at or after the
  // pointer. A stuck channel (enabled, never ready) costs one timeout skip and
  // the search resumes after it. A delivery moves the pointer past the channel.
  task automatic model_route(input logic [7:0] mask, input logic [7:0] stuck,
                             output logic [2:0] ch, output int drops);
    logic [2:0] p;
    logic [2:0] c;
    p = model_ptr;
    c = 3'd0;
    drops = 0;
    for (int n = 0; n < 64; n++) begin
      c = p;
      for (int k = 0; k < 8; k++) begin
        if (mask[c]) break;
        c = c + 3'd1;
      end
      if (!stuck[c]) break;
      drops++;
      p = c + 3'd1;
    end
    ch = c;
    model_ptr = c + 3'd1;
  endtask

  task automatic push_word(input logic [7:0] d, input logic [7:0] mask, input logic [7:0] stuck);
    logic [2:0] ch;
    int drops;
    model_route(mask, stuck, ch, drops);
    exp_q.push_back({ch, d});
    exp_sent++;
    exp_drops += drops;
  endtask

  // Driver: offer one word and hold it until accepted. The task returns one
  // cycle after the accepting edge, which is the SEARCH cycle.
  task automatic send_word(input logic [7:0] d, input bit push, input logic [7:0] stuck);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    in_data  = d;
    in_valid = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    check("accept", ok, 1);
    if (push && ok) push_word(d, chan_en, stuck);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin ok = 1'b1; break; end
    end
    check("idle_reached", ok, 1);
  endtask

  // Monitor: checks one-hot valid, stability during SEND, and delivered words.
  always @(negedge clk) begin
    logic [10:0] e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      check("valid_onehot", ((ch_valid & (ch_valid - 8'd1)) == 8'd0), 1);
      if (ch_valid != 8'd0) begin
        check("valid_busy", busy, 1);
        check("valid_sel", ch_valid, 32'd1 << sel_out);
        if (prev_valid) begin
          check("sel_stable", sel_out, prev_sel);
          check("data_stable", data_out, prev_data);
        end
      end
      if (drop_pulse) drop_seen++;
      if ((ch_valid & ch_ready) != 8'd0) begin
        check("xfer_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("xfer_word", {sel_out, data_out}, e);
        end
      end
      prev_valid = (ch_valid != 8'd0) && ((ch_valid & ch_ready) == 8'd0);
      prev_sel   = sel_out;
      prev_data  = data_out;
    end
  end

  // Main stimulus
  initial begin
    int cnt;
    int dbase;
    bit ok;
    logic [7:0] mask;
    logic [7:0] stuck;

    in_data  = 8'd0;
    in_valid = 1'b0;
    chan_en  = 8'hFF;
    ch_ready = 8'hFF;

    // Reset values
    #1 rst = 1'b1;
    #3;
    check("rst_outputs", {state_dbg, in_ready, sel_out, data_out, ch_valid, drop_pulse, busy}, 0);
    check("rst_sent_cnt", sent_cnt, 0);
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); check("rst_in_ready_low", in_ready, 0);
    @(negedge clk); check("rst_in_ready_up", in_ready, 1);

    // Round robin over all channels, with a latency check on every word
    for (int i = 0; i < 8; i++) begin
      send_word(8'h10 + 8'(i), 1'b1, 8'h00);
      @(negedge clk); check("lat_search", ch_valid, 0);
      @(negedge clk); check("lat_send", ch_valid, 32'd1 << i);
    end
    send_word(8'h18, 1'b1, 8'h00);
    wait_idle();
    check("rr_sent_cnt", sent_cnt, 9);

    // Asynchronous reset while a word is in SEND
    ch_ready = 8'h00;
    send_word(8'h55, 1'b0, 8'h00);
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ch_valid != 8'd0) begin ok = 1'b1; break; end
    end
    check("send_reached", ok, 1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async_rst_outputs", {state_dbg, in_ready, sel_out, data_out, ch_valid, drop_pulse, busy}, 0);
    check("async_rst_sent_cnt", sent_cnt, 0);
    exp_q.delete();
    exp_sent  = 0;
    model_ptr = 3'd0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    ch_ready = 8'hFF;
    @(negedge clk); check("rel_in_ready_low", in_ready, 0);
    @(negedge clk); check("rel_in_ready_up", in_ready, 1);

    // Disabled channels are skipped: expected order 0, 2, 5, 7, 0
    chan_en = 8'b1010_0101;
    for (int i = 0; i < 5; i++) send_word(8'($urandom), 1'b1, 8'h00);
    wait_idle();
    check("skip_sent_cnt", sent_cnt, exp_sent);

    // Timeout on channel 3: the word moves on to channel 4
    chan_en = 8'hFF;
    send_word(8'h01, 1'b1, 8'h00);
    send_word(8'h02, 1'b1, 8'h00);
    wait_idle();
    check("tmo_ptr_model", model_ptr, 3);
    @(posedge clk); #1 ch_ready = 8'hF7;
    dbase = drop_seen;
    send_word(8'hA5, 1'b1, 8'h08);
    cnt = 0;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (ch_valid[3]) cnt++;
      else if (cnt > 0) break;
    end
    check("tmo_valid_cycles", cnt, 16);
    wait_idle();
    check("tmo_drop_once", drop_seen - dbase, 1);
    check("tmo_drops_model", drop_seen, exp_drops);
    ch_ready = 8'hFF;

    // Empty mask blocks input; a mask cleared during SEARCH holds the word
    chan_en = 8'h00;
    repeat (3) @(negedge clk);
    check("empty_in_ready", in_ready, 0);
    @(posedge clk); #1 in_valid = 1'b1; in_data = 8'hEE;
    repeat (3) @(negedge clk);
    check("empty_no_accept", busy, 0);
    @(posedge clk); #1 in_valid = 1'b0;
    chan_en = 8'hFF;
    send_word(8'h3C, 1'b0, 8'h00);
    chan_en = 8'h00;
    repeat (5) @(negedge clk);
    check("held_busy", busy, 1);
    check("held_no_valid", ch_valid, 0);
    push_word(8'h3C, 8'h40, 8'h00);
    @(posedge clk); #1 chan_en = 8'h40;
    wait_idle();
    check("held_sent_cnt", sent_cnt, exp_sent);

    // Ready rises in exactly the timeout cycle: transfer, no drop
    chan_en  = 8'hFF;
    ch_ready = 8'h7F;
    dbase = drop_seen;
    send_word(8'h99, 1'b1, 8'h00);
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (ch_valid[7]) begin ok = 1'b1; break; end
    end
    check("edge_send_reached", ok, 1);
    repeat (15) @(posedge clk);
    #1 ch_ready[7] = 1'b1;
    @(negedge clk); check("edge_valid_still", ch_valid[7], 1);
    wait_idle();
    check("edge_no_drop", drop_seen - dbase, 0);
    check("edge_sent_cnt", sent_cnt, exp_sent);

    // Randomized segments: random mask, random stuck channels, random gaps
    for (int s = 0; s < 10; s++) begin
      mask  = 8'($urandom_range(1, 255));
      stuck = mask & 8'($urandom_range(0, 255));
      if ((mask & ~stuck) == 8'd0) stuck = 8'h00;
      @(posedge clk); #1;
      chan_en  = mask;
      ch_ready = ~stuck;
      for (int w = 0; w < 6; w++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        send_word(8'($urandom), 1'b1, stuck);
      end
      wait_idle();
      check("rand_drops", drop_seen, exp_drops);
      check("rand_sent_cnt", sent_cnt, exp_sent);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
